// File: rtl/irq_controller_pkg.sv
// Shared constants for the CP0 interrupt-source block: IP bit positions,
// Status field indices, the Compare reset value and the request helper.
package irq_controller_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IRQ_W  = 8;
  localparam int unsigned N_EXT  = 5;
  localparam int unsigned N_SW   = 2;

  localparam int unsigned IRQ_TIMER  = 7;
  localparam int unsigned IRQ_EXT_LO = 2;
  localparam int unsigned IRQ_SW_LO  = 0;

  localparam int unsigned ST_IE    = 0;
  localparam int unsigned ST_EXL   = 1;
  localparam int unsigned ST_ERL   = 2;
  localparam int unsigned ST_IM_LO = 8;
  localparam int unsigned ST_IM_HI = 15;

  localparam logic [DATA_W-1:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Request when any unmasked pending exists and the CPU is interruptible.
  function automatic logic irq_request(input logic [IRQ_W-1:0] pend,
                                       input logic [IRQ_W-1:0] im,
                                       input logic             ie,
                                       input logic             exl,
                                       input logic             erl);
    return (|(pend & im)) && ie && !exl && !erl;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One external interrupt line: multi-flop synchronizer followed by either a
// level-following pending bit or a rising-edge latch with write-1-to-clear.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE        = 1'b0
) (
  input  logic clk,
  input  logic res,
  input  logic i_line,
  input  logic i_clr,
  output logic o_pend,
  output logic o_pend_next_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  logic                   r_pend;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_pend_next;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Set beats clear so an edge landing on the clear cycle is never lost.
  always_comb begin
    w_rise      = w_s & ~r_s_prev;
    w_pend_next = EDGE ? (w_rise | (r_pend & ~i_clr)) : w_s;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_sync   <= '0;
      r_s_prev <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_line};
      r_s_prev <= w_s;
      r_pend   <= w_pend_next;
    end
  end

  assign o_pend        = r_pend;
  assign o_pend_next_c = w_pend_next;

endmodule

// File: rtl/irq_controller.sv
// CP0 interrupt sources: synchronized device lines, software bits and the
// Count/Compare timer, combined into the registered irq vector and extInt.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [N_EXT-1:0] EDGE_MASK   = 5'b00000
) (
  input  logic              clk,
  input  logic              res,
  input  logic [N_EXT-1:0]  ext_irq,
  input  logic [N_SW-1:0]   sw_irq,
  input  logic [DATA_W-1:0] cp0_status,
  input  logic              we_count,
  input  logic              we_compare,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr_we,
  input  logic [N_EXT-1:0]  clr_mask,
  output logic [IRQ_W-1:0]  irq,
  output logic              extInt,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] compare
);

  logic [N_EXT-1:0]  w_ext_pend;
  logic [N_EXT-1:0]  w_ext_pend_next;
  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] r_compare;
  logic              r_timer;
  logic [N_SW-1:0]   r_sw;
  logic              r_ext_int;
  logic [DATA_W-1:0] w_count_next;
  logic [DATA_W-1:0] w_compare_next;
  logic              w_match;
  logic              w_timer_next;
  logic [IRQ_W-1:0]  w_irq_next;
  logic              w_ext_int_next;
  logic              w_unused_status;

  for (genvar gi = 0; gi < int'(N_EXT); gi++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE       (EDGE_MASK[gi])
    ) u_line (
      .clk          (clk),
      .res          (res),
      .i_line       (ext_irq[gi]),
      .i_clr        (clr_we && clr_mask[gi]),
      .o_pend       (w_ext_pend[gi]),
      .o_pend_next_c(w_ext_pend_next[gi])
    );
  end

  // Timer match compares the value about to land in Count against the current Compare.
  always_comb begin
    w_count_next   = we_count ? wdata : r_count + DATA_W'(1);
    w_compare_next = we_compare ? wdata : r_compare;
    w_match        = (w_count_next == r_compare);
    w_timer_next   = we_compare ? 1'b0 : (r_timer | w_match);
  end

  always_comb begin
    w_irq_next                        = '0;
    w_irq_next[IRQ_TIMER]             = w_timer_next;
    w_irq_next[IRQ_EXT_LO +: N_EXT]   = w_ext_pend_next;
    w_irq_next[IRQ_SW_LO +: N_SW]     = sw_irq;
    w_ext_int_next = irq_request(w_irq_next,
                                 cp0_status[ST_IM_HI:ST_IM_LO],
                                 cp0_status[ST_IE],
                                 cp0_status[ST_EXL],
                                 cp0_status[ST_ERL]);
  end

  assign w_unused_status = ^{cp0_status[DATA_W-1:ST_IM_HI+1],
                             cp0_status[ST_IM_LO-1:ST_ERL+1]};

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_count   <= '0;
      r_compare <= COMPARE_RST;
      r_timer   <= 1'b0;
      r_sw      <= '0;
      r_ext_int <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_compare <= w_compare_next;
      r_timer   <= w_timer_next;
      r_sw      <= sw_irq;
      r_ext_int <= w_ext_int_next;
    end
  end

  always_comb begin
    irq                       = '0;
    irq[IRQ_TIMER]            = r_timer;
    irq[IRQ_EXT_LO +: N_EXT]  = w_ext_pend;
    irq[IRQ_SW_LO +: N_SW]    = r_sw;
  end

  assign extInt  = r_ext_int;
  assign count   = r_count;
  assign compare = r_compare;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: vector table for sync/edge/mask behaviour,
// hand sequences for reset, timer, wrap-around and same-cycle collisions.
module tb_irq_controller;

  logic        clk;
  logic        res;
  logic [4:0]  ext_irq;
  logic [1:0]  sw_irq;
  logic [31:0] cp0_status;
  logic        we_count;
  logic        we_compare;
  logic [31:0] wdata;
  logic        clr_we;
  logic [4:0]  clr_mask;
  logic [7:0]  irq;
  logic        ext_int;
  logic [31:0] count;
  logic [31:0] compare;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  ext;
    logic [1:0]  sw;
    logic [31:0] status;
    logic        clr;
    logic [4:0]  mask;
    logic [7:0]  exp_irq;
    logic        exp_int;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs [NV];

  irq_controller #(
    .SYNC_STAGES(2),
    .EDGE_MASK  (5'b00010)
  ) dut (
    .clk       (clk),
    .res       (res),
    .ext_irq   (ext_irq),
    .sw_irq    (sw_irq),
    .cp0_status(cp0_status),
    .we_count  (we_count),
    .we_compare(we_compare),
    .wdata     (wdata),
    .clr_we    (clr_we),
    .clr_mask  (clr_mask),
    .irq       (irq),
    .extInt    (ext_int),
    .count     (count),
    .compare   (compare)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // ext,     sw,    status,       clr,  mask,     irq,   extInt
    vecs[0]  = '{5'b00001, 2'b00, 32'h0000_0401, 1'b0, 5'b00000, 8'h00, 1'b0};
    vecs[1]  = '{5'b00001, 2'b00, 32'h0000_0401, 1'b0, 5'b00000, 8'h00, 1'b0};
    vecs[2]  = '{5'b00001, 2'b00, 32'h0000_0401, 1'b0, 5'b00000, 8'h04, 1'b1};
    vecs[3]  = '{5'b00001, 2'b00, 32'h0000_0403, 1'b0, 5'b00000, 8'h04, 1'b0};
    vecs[4]  = '{5'b00000, 2'b00, 32'h0000_0401, 1'b0, 5'b00000, 8'h04, 1'b1};
    vecs[5]  = '{5'b00000, 2'b00, 32'h0000_0401, 1'b0, 5'b00000, 8'h04, 1'b1};
    vecs[6]  = '{5'b00000, 2'b00, 32'h0000_0401, 1'b0, 5'b00000, 8'h00, 1'b0};
    vecs[7]  = '{5'b00010, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h00, 1'b0};
    vecs[8]  = '{5'b00010, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h00, 1'b0};
    vecs[9]  = '{5'b00010, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h08, 1'b1};
    vecs[10] = '{5'b00000, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h08, 1'b1};
    vecs[11] = '{5'b00000, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h08, 1'b1};
    vecs[12] = '{5'b00000, 2'b00, 32'h0000_0801, 1'b1, 5'b00010, 8'h00, 1'b0};
    vecs[13] = '{5'b00010, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h00, 1'b0};
    vecs[14] = '{5'b00010, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h00, 1'b0};
    vecs[15] = '{5'b00010, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h08, 1'b1};
    vecs[16] = '{5'b00000, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h08, 1'b1};
    vecs[17] = '{5'b00000, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h08, 1'b1};
    vecs[18] = '{5'b00010, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h08, 1'b1};
    vecs[19] = '{5'b00010, 2'b00, 32'h0000_0801, 1'b0, 5'b00000, 8'h08, 1'b1};
    vecs[20] = '{5'b00010, 2'b00, 32'h0000_0801, 1'b1, 5'b00010, 8'h08, 1'b1};
    vecs[21] = '{5'b00010, 2'b00, 32'h0000_0801, 1'b1, 5'b00010, 8'h00, 1'b0};
    vecs[22] = '{5'b00011, 2'b00, 32'h0000_0C01, 1'b0, 5'b00000, 8'h00, 1'b0};
    vecs[23] = '{5'b00011, 2'b00, 32'h0000_0C01, 1'b0, 5'b00000, 8'h00, 1'b0};
    vecs[24] = '{5'b00011, 2'b00, 32'h0000_0C01, 1'b1, 5'b00001, 8'h04, 1'b1};
    vecs[25] = '{5'b00011, 2'b00, 32'h0000_0C01, 1'b1, 5'b11111, 8'h04, 1'b1};
    vecs[26] = '{5'b00000, 2'b00, 32'h0000_0C01, 1'b0, 5'b00000, 8'h04, 1'b1};
    vecs[27] = '{5'b00000, 2'b00, 32'h0000_0C01, 1'b0, 5'b00000, 8'h04, 1'b1};
    vecs[28] = '{5'b00000, 2'b00, 32'h0000_0C01, 1'b0, 5'b00000, 8'h00, 1'b0};
    vecs[29] = '{5'b00000, 2'b01, 32'h0000_0001, 1'b0, 5'b00000, 8'h01, 1'b0};
    vecs[30] = '{5'b00000, 2'b01, 32'h0000_0101, 1'b0, 5'b00000, 8'h01, 1'b1};
    vecs[31] = '{5'b00000, 2'b01, 32'h0000_0105, 1'b0, 5'b00000, 8'h01, 1'b0};
    vecs[32] = '{5'b00000, 2'b10, 32'h0000_0201, 1'b0, 5'b00000, 8'h02, 1'b1};
    vecs[33] = '{5'b00000, 2'b00, 32'h0000_0201, 1'b0, 5'b00000, 8'h00, 1'b0};
    vecs[34] = '{5'b00000, 2'b01, 32'h0000_0100, 1'b0, 5'b00000, 8'h01, 1'b0};

    res        = 1'b0;
    ext_irq    = '0;
    sw_irq     = '0;
    cp0_status = '0;
    we_count   = 1'b0;
    we_compare = 1'b0;
    wdata      = '0;
    clr_we     = 1'b0;
    clr_mask   = '0;

    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      ext_irq    = 5'(i * 7 + 1);
      sw_irq     = 2'(i + 1);
      cp0_status = 32'h0000_FF01;
      we_count   = i[0];
      we_compare = ~i[0];
      wdata      = 32'(i * 1000 + 3);
      step();
      check("reset irq", 32'(irq), 32'h0);
      check("reset extInt", 32'(ext_int), 32'h0);
      check("reset count", count, 32'h0);
      check("reset compare", compare, 32'hFFFF_FFFF);
    end
    ext_irq    = '0;
    sw_irq     = '0;
    cp0_status = '0;
    we_count   = 1'b0;
    we_compare = 1'b0;
    wdata      = '0;
    res        = 1'b1;
    step();
    check("first count", count, 32'h1);
    check("first irq", 32'(irq), 32'h0);

    for (int i = 0; i < NV; i++) begin
      ext_irq    = vecs[i].ext;
      sw_irq     = vecs[i].sw;
      cp0_status = vecs[i].status;
      clr_we     = vecs[i].clr;
      clr_mask   = vecs[i].mask;
      step();
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      check($sformatf("vec%0d extInt", i), 32'(ext_int), 32'(vecs[i].exp_int));
    end
    ext_irq    = '0;
    sw_irq     = '0;
    clr_we     = 1'b0;
    clr_mask   = '0;
    cp0_status = 32'h0000_8001;

    // Timer: Count=10, Compare=15
    we_count = 1'b1; wdata = 32'd10; step(); we_count = 1'b0;
    check("cnt load", count, 32'd10);
    we_compare = 1'b1; wdata = 32'd15; step(); we_compare = 1'b0;
    check("cmp load", compare, 32'd15);
    check("cnt after cmp", count, 32'd11);
    step(); step(); step();
    check("cnt 14", count, 32'd14);
    check("timer before match", 32'(irq[7]), 32'h0);
    step();
    check("cnt 15", count, 32'd15);
    check("timer at match", 32'(irq[7]), 32'h1);
    check("extInt at match", 32'(ext_int), 32'h1);
    step();
    check("timer held", 32'(irq[7]), 32'h1);
    we_compare = 1'b1; wdata = 32'd100; step(); we_compare = 1'b0;
    check("timer cleared", 32'(irq[7]), 32'h0);
    check("extInt cleared", 32'(ext_int), 32'h0);

    // Wrap-around match with Compare = 0
    we_compare = 1'b1; wdata = 32'd0; step(); we_compare = 1'b0;
    we_count = 1'b1; wdata = 32'hFFFF_FFFE; step(); we_count = 1'b0;
    check("cnt FFFFFFFE", count, 32'hFFFF_FFFE);
    step();
    check("cnt FFFFFFFF", count, 32'hFFFF_FFFF);
    check("timer pre-wrap", 32'(irq[7]), 32'h0);
    step();
    check("cnt wrap", count, 32'h0);
    check("timer wrap", 32'(irq[7]), 32'h1);

    // Count write to Compare-1 matches on the next increment
    we_compare = 1'b1; wdata = 32'd50; step(); we_compare = 1'b0;
    check("timer clr2", 32'(irq[7]), 32'h0);
    we_count = 1'b1; wdata = 32'd49; step(); we_count = 1'b0;
    check("timer at 49", 32'(irq[7]), 32'h0);
    step();
    check("cnt 50", count, 32'd50);
    check("timer at 50", 32'(irq[7]), 32'h1);

    // Match and compare write on the same edge: clear wins
    we_compare = 1'b1; wdata = 32'd200; step(); we_compare = 1'b0;
    we_count = 1'b1; wdata = 32'd199; step(); we_count = 1'b0;
    we_compare = 1'b1; wdata = 32'd200; step(); we_compare = 1'b0;
    check("cnt 200", count, 32'd200);
    check("clear beats match", 32'(irq[7]), 32'h0);

    // Count write overrides the increment
    we_count = 1'b1; wdata = 32'h0000_1234; step(); we_count = 1'b0;
    check("cnt write wins", count, 32'h0000_1234);
    we_count = 1'b1; wdata = 32'd200; step(); we_count = 1'b0;
    check("load match", 32'(irq[7]), 32'h1);

    // Asynchronous reset mid-operation
    sw_irq  = 2'b11;
    ext_irq = 5'b00001;
    step(); step(); step();
    check("pre-reset irq", 32'(irq), 32'h87);
    check("pre-reset extInt", 32'(ext_int), 32'h1);
    #2 res = 1'b0;
    #1;
    check("async rst irq", 32'(irq), 32'h0);
    check("async rst extInt", 32'(ext_int), 32'h0);
    check("async rst count", count, 32'h0);
    check("async rst compare", compare, 32'hFFFF_FFFF);
    step();
    res = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt-source block for the CPU's CP0 exception path. It synchronizes the external device interrupt lines and owns the Count/Compare timer. It produces the registered 8-bit `irq` vector (IP7..IP0) and the `extInt` request that the exception priority logic consumes. It holds edge-type interrupts pending until software clears them, and it suppresses the request while the CPU is already in exception or error level.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops per external line, minimum 2.
- `EDGE_MASK`, default 5'b00000: per external line; 1 = rising-edge latched, 0 = level.

Ports:
- `clk`  in  1  single clock.
- `res`  in  1  reset, asynchronous, active-low.
- `ext_irq`  in  5  asynchronous device lines, mapped to IP6..IP2.
- `sw_irq`  in  2  software interrupt bits from Cause[9:8], mapped to IP1..IP0.
- `cp0_status`  in  32  current Status: IM = [15:8], IE = [0], EXL = [1], ERL = [2].
- `we_count`  in  1  write Count.
- `we_compare`  in  1  write Compare; clears the timer interrupt.
- `wdata`  in  32  write data for Count and Compare.
- `clr_we`  in  1  write-1-to-clear strobe for latched edge pendings.
- `clr_mask`  in  5  lines to clear, same bit mapping as `ext_irq`.
- `irq`  out  8  registered pending vector; IP7 = timer.
- `extInt`  out  1  registered request: unmasked pending exists and the CPU is interruptible.
- `count`  out  32  Count register.
- `compare`  out  32  Compare register.

## Operation

- **Synchronizer.** Each `ext_irq` bit passes through `SYNC_STAGES` flops. The result is the synchronized line `s[i]`.
- **Level lines** (`EDGE_MASK[i]` = 0): the pending bit follows `s[i]`, registered.
- **Edge lines** (`EDGE_MASK[i]` = 1):
  - A rising edge is detected when `s[i]` = 1 and the previous `s[i]` = 0. It sets the pending bit.
  - `clr_we && clr_mask[i]` clears the pending bit.
  - If an edge and a clear occur on the same cycle, the set wins, so no edge is lost.
  - `clr_mask` bits for level lines are ignored.
- **Count.**
  - Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - `we_count` loads `wdata` instead of incrementing that cycle.
- **Compare.** `we_compare` loads `wdata`.
- **Timer pending (IP7).**
  - Set when the Count value being written into the register equals Compare. "Being written" means the incremented value or the loaded `wdata`.
  - Cleared by `we_compare`. A clear on the same cycle as a match wins.
  - Match uses the current Compare value, not the value being written.
- **irq vector.** `irq = {timer_pend, ext_pend[4:0], sw_irq}`, all bits registered. `sw_irq` is registered once.
- **extInt.** Next-state value is `|(irq_next & cp0_status[15:8]) && cp0_status[0] && !cp0_status[1] && !cp0_status[2]`, then registered.
- **No acknowledge handshake.** The request stays asserted until the source is removed or cleared, or until EXL/ERL/IE/IM masks it.

## Timing

- Reset values (`res` low, asynchronous):
  - synchronizers, pendings, `irq`, `extInt` and `count` are 0;
  - `compare` is 0xFFFFFFFF.
- Reset asserted mid-operation clears every pending immediately; there is no partial state.
- External latency: a line stable high before edge E appears in `irq` at edge E+`SYNC_STAGES`. `extInt` is asserted on the same edge, since it is computed from `irq_next`.
- Level deassertion removes the bit with the same latency.
- Software bits: `sw_irq` change at edge E is reflected in `irq`/`extInt` at edge E+1.
- Timer: if Count becomes equal to Compare at edge E, `irq[7]` and `extInt` rise at edge E.
  - `we_compare` at edge E drops `irq[7]` at edge E.
  - Count write to Compare−1 yields a match on the following increment.
- Mask changes: a Status change at edge E affects `extInt` at edge E+1.
- Wrap-around: Count 0xFFFFFFFF → 0 is a normal increment and matches Compare = 0.

## Structure

- Shared package/header (with `CPU.vh`):
  - IP bit positions (`IRQ_TIMER` = 7, `IRQ_EXT_LO` = 2, `IRQ_SW_LO` = 0);
  - Status field indices (IE, EXL, ERL, IM range);
  - Compare reset constant.
- One sub-module, `irq_sync_edge`: a per-line synchronizer plus optional edge latch with clear. It is instantiated 5 times via generate, with the edge/level mode taken from `EDGE_MASK`.
- Count/Compare and the `extInt` logic stay in the top.

## Test plan

1. **Reset.** Hold `res` low, toggle inputs → `irq` = 0, `extInt` = 0, `count` = 0, `compare` = 0xFFFFFFFF. After release, `count` = 1 on the first edge.
2. **Level line.** `EDGE_MASK` = 0. Status = 0x00000401 (IM2 = 1, IE = 1). Raise `ext_irq[0]` → `irq` = 0x04 and `extInt` = 1 after exactly 2 edges. Set EXL → `extInt` = 0 next edge, with `irq` unchanged.
3. **Edge line.** `EDGE_MASK` = 5'b00010. Pulse `ext_irq[1]` for 3 cycles → `irq[3]` stays set after the line falls. `clr_we` with `clr_mask` = 5'b00010 → cleared next edge. A new edge coincident with the clear → remains set.
4. **Timer.**
   - Write Count = 10, Compare = 15 → `irq[7]` rises on the edge where `count` becomes 15.
   - `we_compare` → `irq[7]` = 0.
   - Compare = 0, Count = 0xFFFFFFFE → match at wrap.
5. **Masking.** `sw_irq` = 2'b01 with IM = 0x00 → `irq` = 0x01 and `extInt` = 0. Set IM0 and IE → `extInt` = 1 next edge. Set ERL → 0.
6. **Simultaneous events.** Timer match and `we_compare` on the same edge → `irq[7]` stays 0. `we_count` and the increment on the same cycle → `count` = `wdata`.
